// File: rtl/cordic_phase_front.sv
// Phase accumulator front end for the pipelined CORDIC core: folds each NCO sample
// into +/-pi/2, scales it to Q2.6 radians, and delays the cosine-negate flag to the core output.
module cordic_phase_front #(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned LATENCY = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] fcw,
  input  logic               load_phase,
  input  logic [PHASE_W-1:0] phase_init,
  output logic [7:0]         angle,
  output logic               angle_valid,
  output logic               flip,
  output logic               flip_valid
);

  localparam int unsigned FOLD_W = PHASE_W + 1;
  localparam int unsigned PROD_W = PHASE_W + 9;
  localparam int unsigned SHIFT  = PHASE_W - 1;

  localparam logic signed [FOLD_W-1:0] QTR    = FOLD_W'(1) << (PHASE_W - 2);
  localparam logic signed [FOLD_W-1:0] HALF   = FOLD_W'(1) << (PHASE_W - 1);
  localparam logic signed [PROD_W-1:0] K_SCALE = PROD_W'(201);
  localparam logic signed [PROD_W-1:0] ROUND  = PROD_W'(1) << (PHASE_W - 2);
  localparam logic signed [PROD_W-1:0] SAT    = PROD_W'(100);

  logic [PHASE_W-1:0]       acc;
  logic                     s1_valid;
  logic signed [FOLD_W-1:0] s1_fold;
  logic                     s1_flip;
  logic                     s2_flip;
  logic [LATENCY-1:0]       dl_valid;
  logic [LATENCY-1:0]       dl_flip;

  logic signed [FOLD_W-1:0] phase_c;
  logic signed [FOLD_W-1:0] fold_c;
  logic                     fold_flip_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] scaled_c;
  logic signed [7:0]        sat_c;

  // Fold the signed phase into [-pi/2, pi/2]; the far half-circle marks the cosine for negation.
  always_comb begin
    phase_c     = {acc[PHASE_W-1], acc};
    fold_c      = phase_c;
    fold_flip_c = 1'b0;
    if (phase_c > QTR) begin
      fold_c      = HALF - phase_c;
      fold_flip_c = 1'b1;
    end else if (phase_c < -QTR) begin
      fold_c      = -HALF - phase_c;
      fold_flip_c = 1'b1;
    end
  end

  // Scale by 201/2^(PHASE_W-1) (~ 64*pi / full-scale) with round-half-up, then clip to +/-100.
  always_comb begin
    prod_c   = PROD_W'(s1_fold) * K_SCALE + ROUND;
    scaled_c = prod_c >>> SHIFT;
    sat_c    = 8'(scaled_c);
    if (scaled_c > SAT) begin
      sat_c = 8'sd100;
    end else if (scaled_c < -SAT) begin
      sat_c = -8'sd100;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      s1_valid    <= 1'b0;
      s1_fold     <= '0;
      s1_flip     <= 1'b0;
      angle       <= '0;
      angle_valid <= 1'b0;
      s2_flip     <= 1'b0;
      dl_valid    <= '0;
      dl_flip     <= '0;
    end else begin
      if (load_phase) begin
        acc <= phase_init;
      end else if (en) begin
        acc <= acc + fcw;
      end

      s1_valid <= en;
      if (en) begin
        s1_fold <= fold_c;
        s1_flip <= fold_flip_c;
      end

      angle_valid <= s1_valid;
      s2_flip     <= s1_valid & s1_flip;
      if (s1_valid) begin
        angle <= sat_c;
      end

      // Free-running delay line; invalid slots always carry flip=0.
      dl_valid[0] <= angle_valid;
      dl_flip[0]  <= s2_flip;
      for (int i = 1; i < int'(LATENCY); i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_flip[i]  <= dl_flip[i-1];
      end
    end
  end

  assign flip_valid = dl_valid[LATENCY-1];
  assign flip       = dl_flip[LATENCY-1];

endmodule

// File: tb/tb_cordic_phase_front.sv
// Randomized scoreboard bench for cordic_phase_front against an integer reference model.
module tb_cordic_phase_front;

  localparam int PW  = 16;
  localparam int LAT = 8;
  localparam int MOD = 1 << PW;
  localparam int QTR = 1 << (PW - 2);
  localparam int HLF = 1 << (PW - 1);

  logic          clk;
  logic          rst;
  logic          en;
  logic [PW-1:0] fcw;
  logic          load_phase;
  logic [PW-1:0] phase_init;
  logic [7:0]    angle;
  logic          angle_valid;
  logic          flip;
  logic          flip_valid;

  cordic_phase_front #(.PHASE_W(PW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fcw        (fcw),
    .load_phase (load_phase),
    .phase_init (phase_init),
    .angle      (angle),
    .angle_valid(angle_valid),
    .flip       (flip),
    .flip_valid (flip_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t aq[$];
  exp_t fq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   model_acc = 0;
  logic rst_d = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  // Reference: fold a signed phase to +/-pi/2 and convert to Q2.6 radians.
  function automatic void ref_fold(input int p, output int ang, output int fl);
    int f;
    f  = p;
    fl = 0;
    if (p > QTR) begin
      f  = HLF - p;
      fl = 1;
    end else if (p < -QTR) begin
      f  = -HLF - p;
      fl = 1;
    end
    ang = (f * 201 + QTR) >>> (PW - 1);
    if (ang > 100) ang = 100;
    if (ang < -100) ang = -100;
  endfunction

  // Drive one cycle of inputs and advance the model in step with the DUT.
  task automatic step(input logic r, input logic e, input logic l, input int init, input int f);
    int p;
    int a;
    int fl;
    rst        = r;
    en         = e;
    load_phase = l;
    phase_init = PW'(init);
    fcw        = PW'(f);
    if (r) begin
      model_acc = 0;
      for (int i = aq.size() - 1; i >= 0; i--) if (aq[i].due > cyc) aq.delete(i);
      for (int i = fq.size() - 1; i >= 0; i--) if (fq[i].due > cyc) fq.delete(i);
    end else begin
      if (e) begin
        p = (model_acc >= HLF) ? model_acc - MOD : model_acc;
        ref_fold(p, a, fl);
        aq.push_back('{cyc + 2, a});
        fq.push_back('{cyc + 2 + LAT, fl});
      end
      if (l) model_acc = init & (MOD - 1);
      else if (e) model_acc = (model_acc + (f & (MOD - 1))) % MOD;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    exp_t it;
    if (rst_d) begin
      n_chk++;
      if (angle == 8'd0 && !angle_valid && !flip && !flip_valid) n_pass++;
      else $display("FAIL reset_outputs cyc=%0d got angle=%0d av=%0b flip=%0b fv=%0b exp all 0",
                    cyc, $signed(angle), angle_valid, flip, flip_valid);
    end

    if (angle_valid) begin
      n_chk++;
      if (aq.size() > 0 && aq[0].due == cyc) begin
        it = aq.pop_front();
        if (int'($signed(angle)) == it.val) n_pass++;
        else $display("FAIL angle cyc=%0d got=%0d exp=%0d", cyc, $signed(angle), it.val);
      end else begin
        $display("FAIL angle_valid_unexpected cyc=%0d got=1 exp=0", cyc);
      end
    end else if (aq.size() > 0 && aq[0].due == cyc) begin
      n_chk++;
      it = aq.pop_front();
      $display("FAIL angle_valid_missing cyc=%0d got=0 exp=1 (angle %0d)", cyc, it.val);
    end

    if (flip_valid) begin
      n_chk++;
      if (fq.size() > 0 && fq[0].due == cyc) begin
        it = fq.pop_front();
        if (int'(flip) == it.val) n_pass++;
        else $display("FAIL flip cyc=%0d got=%0b exp=%0d", cyc, flip, it.val);
      end else begin
        $display("FAIL flip_valid_unexpected cyc=%0d got=1 exp=0", cyc);
      end
    end else begin
      n_chk++;
      if (!flip) n_pass++;
      else $display("FAIL flip_idle cyc=%0d got=1 exp=0", cyc);
      if (fq.size() > 0 && fq[0].due == cyc) begin
        n_chk++;
        it = fq.pop_front();
        $display("FAIL flip_valid_missing cyc=%0d got=0 exp=1 (flip %0d)", cyc, it.val);
      end
    end
  end

  int dir_phase[7] = '{'h2000, 'h6000, 'h8000, 'hA000, 'h4000, 'hC000, 'h4001};
  int edge_phase[6] = '{'h4000, 'h4001, 'hC000, 'hBFFF, 'h8000, 'h3FFF};
  int gap_pat[5] = '{1, 0, 1, 1, 0};

  initial begin
    logic r;
    logic e;
    logic l;
    int   init;
    rst = 1'b1; en = 1'b0; load_phase = 1'b0; phase_init = '0; fcw = '0;

    repeat (3) step(1'b1, 1'b1, 1'b0, 0, 'h0100);
    repeat (5) step(1'b0, 1'b0, 1'b0, 0, 'h0100);

    foreach (dir_phase[i]) begin
      step(1'b0, 1'b0, 1'b1, dir_phase[i], 0);
      step(1'b0, 1'b1, 1'b0, 0, 0);
    end
    repeat (LAT + 4) step(1'b0, 1'b0, 1'b0, 0, 0);

    step(1'b0, 1'b0, 1'b1, 0, 'h0800);
    repeat (40) step(1'b0, 1'b1, 1'b0, 0, 'h0800);
    foreach (gap_pat[i]) step(1'b0, gap_pat[i][0], 1'b0, 0, 'h0800);
    repeat (LAT + 4) step(1'b0, 1'b0, 1'b0, 0, 'h0800);

    repeat (10) step(1'b0, 1'b1, 1'b0, 0, 'h0800);
    step(1'b1, 1'b1, 1'b0, 0, 'h0800);
    repeat (LAT + 4) step(1'b0, 1'b0, 1'b0, 0, 'h0800);
    repeat (6) step(1'b0, 1'b1, 1'b0, 0, 'h0800);

    repeat (400) begin
      r    = ($urandom_range(0, 49) == 0);
      e    = ($urandom_range(0, 3) != 0);
      l    = ($urandom_range(0, 9) == 0);
      init = ($urandom_range(0, 1) == 0) ? edge_phase[$urandom_range(0, 5)]
                                         : int'($urandom_range(0, MOD - 1));
      step(r, e, l, init, int'($urandom_range(0, MOD - 1)));
    end

    repeat (LAT + 6) step(1'b0, 1'b0, 1'b0, 0, 0);

    n_chk++;
    if (aq.size() == 0 && fq.size() == 0) n_pass++;
    else $display("FAIL drain got angle_left=%0d flip_left=%0d exp 0", aq.size(), fq.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_phase_front.md
Name: cordic_phase_front

Overview:
- Upstream stage of the pipelined CORDIC sine/cosine core.
- Runs a phase accumulator (NCO) across the full circle and folds each phase sample into ±π/2.
- Emits the folded angle as signed 8-bit Q2.6 radians, the format the CORDIC `in` port expects.
- Delays a per-sample "negate cosine" flag by the CORDIC pipeline depth, so downstream logic can fix quadrants 2/3 on the cosine output in step with the core.

Parameters:
- PHASE_W, 16, accumulator width; 2^PHASE_W counts = 2π; phase read as signed, range [-π, π).
- LATENCY, 8, CORDIC core pipeline depth in cycles; length of the flag delay line; must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  sample strobe: emit the current phase and advance the accumulator.
- fcw  in  PHASE_W  frequency control word, unsigned increment per en.
- load_phase  in  1  synchronous load of the accumulator.
- phase_init  in  PHASE_W  value loaded when load_phase=1.
- angle  out  8  signed Q2.6 folded angle, drives the CORDIC `in`.
- angle_valid  out  1  angle qualifier.
- flip  out  1  1 = the CORDIC cosine for this sample must be negated; aligned to the CORDIC output.
- flip_valid  out  1  flip qualifier; equals angle_valid delayed by LATENCY cycles.

Behaviour:
- Reset (rst=1 at an edge):
  - acc=0; angle=0, angle_valid=0, flip=0, flip_valid=0.
  - All pipeline and delay-line registers cleared.
  - Reset overrides en and load_phase.
- Accumulator priority:
  - load_phase=1: acc <= phase_init.
  - else en=1: acc <= acc + fcw, modulo 2^PHASE_W (natural wrap, no saturation).
  - else hold.
- Sampling:
  - A cycle with en=1 samples the pre-update acc value p, interpreted as signed.
  - With load_phase and en both high, the sample is still the old acc; phase_init is sampled on the next en.
- Stage 1, fold (registered):
  - |p| ≤ 2^(PHASE_W-2): f = p, flip1 = 0.
  - p > 2^(PHASE_W-2): f = 2^(PHASE_W-1) − p, flip1 = 1.
  - p < −2^(PHASE_W-2): f = −2^(PHASE_W-1) − p, flip1 = 1.
  - Compute on PHASE_W+1 bits. p = −2^(PHASE_W-1) gives f = 0, flip1 = 1.
- Stage 2, scale (registered):
  - angle = (f·201 + 2^(PHASE_W-2)) >>> (PHASE_W-1), arithmetic shift. 201 ≈ 64π; the add rounds half up.
  - Saturate to [−100, +100] (i.e. ±π/2 in Q2.6, 100.53 clipped).
  - The product needs PHASE_W+9 bits.
- Latency and throughput:
  - angle and angle_valid appear exactly 2 cycles after the en cycle.
  - Full throughput: one sample per cycle. Gaps in en propagate unchanged.
- Flip delay line:
  - A LATENCY-deep shift register carries {angle_valid, flip2}.
  - flip and flip_valid appear 2+LATENCY cycles after en.
  - The line shifts every cycle regardless of en. flip is held at 0 when flip_valid=0.
- Reset mid-stream:
  - All in-flight samples are discarded; no valid or flip from before reset appears afterwards.
  - The first sample after release is acc=0 unless loaded.
- fcw changes take effect on the next en. Changing fcw never disturbs samples already in flight.

Test Plan:
- Reset: hold rst 3 cycles with en=1, fcw=0x0100 → all outputs 0 and acc stays 0. Release with en=0 → angle_valid never asserts.
- π/4: load 0x2000, then en=1 with fcw=0 → angle=50 and flip=0 at en+2 with angle_valid=1; flip_valid=1, flip=0 at en+10.
- 3π/4 and −π:
  - Load 0x6000 → angle=50 at en+2, flip=1 at en+10.
  - Load 0x8000 → angle=0 at en+2, flip=1 at en+10.
  - Load 0xA000 → angle=−50 at en+2, flip=1 at en+10.
- Saturation and boundary:
  - Load 0x4000 → angle=+100 (101 clipped), flip=0.
  - Load 0xC000 → angle=−100, flip=0.
  - Load 0x4001 → angle=100, flip=1.
- Sweep: fcw=0x0800, en held 40 cycles → 32-sample period, acc wraps 0xF800→0x0000, angle_valid continuous. Angle rises 0→100, falls back to −100, then returns to 0. flip=1 exactly for phases 0x4800–0xB800.
- Gaps and mid-stream reset:
  - en pattern 1,0,1,1,0 → angle_valid shows the same pattern shifted 2 cycles; flip_valid shows it shifted 10 cycles.
  - rst pulsed for 1 cycle mid-sweep → all valids 0 from the next edge; no stale flip_valid within 10 cycles after release.
